// File: rtl/mlaccel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlaccel_pkg
// Description : Shared types and constants for the accelerator banked memory:
//               FSM state encoding, lane geometry and a clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mlaccel_pkg;

  // Every bank stores 16-bit words, written as two independent bytes.
  localparam int LANE_W         = 16;
  localparam int BYTES_PER_LANE = 2;

  // Request sequencer states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlaccel_bankmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : mlaccel_bankmem_ram
// Description : One memory bank, DEPTH x 16, synchronous read, per-byte write
//               enable. Single-port; at 16384 words it maps onto one
//               SB_SPRAM256KA. Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mlaccel_bankmem_ram
  import mlaccel_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic [AW-1:0]     addr,
  input  logic [1:0]        wen,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] r_mem [DEPTH];

  // Byte-masked write and registered read at the same address.
  always_ff @(posedge clock) begin
    if (wen[0]) r_mem[addr][7:0]  <= wdata[7:0];
    if (wen[1]) r_mem[addr][15:8] <= wdata[15:8];
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/mlaccel_bankmem.sv
`default_nettype none
// ============================================================================
// Module      : mlaccel_bankmem
// Description : NBANKS-way banked word memory with unaligned multi-word
//               access, valid/ready request and response channels, read
//               bursts, and a credit-controlled 2-entry response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mlaccel_bankmem
  import mlaccel_pkg::*;
#(
  parameter int NBANKS     = 4,
  parameter int BANK_DEPTH = 16384,
  parameter int ADDR_W     = 16,   // must equal log2(NBANKS*BANK_DEPTH)
  parameter int LEN_W      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [BYTES_PER_LANE*NBANKS-1:0] req_wen,
  input  logic [LANE_W*NBANKS-1:0]     req_wdata,
  input  logic [LEN_W-1:0]             req_len,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [LANE_W*NBANKS-1:0]     rsp_data,
  output logic                         rsp_last
);

  localparam int SHIFT_W = clog2(NBANKS);
  localparam int ROW_W   = clog2(BANK_DEPTH);
  localparam int DATA_W  = LANE_W * NBANKS;
  localparam int BE_W    = BYTES_PER_LANE * NBANKS;

  // Sequencer
  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_idx;
  logic [LEN_W-1:0]    r_len;
  logic                w_accept, w_is_write;
  logic                w_wr, w_rd_issue, w_issue_last;
  logic [ADDR_W-1:0]   w_issue_addr;

  // Bank addressing and lane routing
  logic [ROW_W-1:0]    w_base_row, w_row_next;
  logic [SHIFT_W-1:0]  w_shift;
  logic [DATA_W-1:0]   w_bank_wdata, w_bank_rdata, w_rot_rdata;
  logic [BE_W-1:0]     w_bank_wen;

  // Read stage (one beat in flight inside the RAMs)
  logic                r_rd_valid, r_rd_last;
  logic [SHIFT_W-1:0]  r_rd_shift;

  // Response FIFO
  logic [DATA_W-1:0]   r_fifo_data [2];
  logic [1:0]          r_fifo_last;
  logic                r_wptr, r_rptr;
  logic [1:0]          r_count;
  logic                w_pop, w_credit;
  logic [2:0]          w_occ;

  // A new beat may be issued only if it is guaranteed a FIFO slot once it
  // leaves the read stage: beats already committed, less the one leaving now.
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_occ     = 3'(r_rd_valid) + 3'(r_count) - 3'(w_pop);
  assign w_credit  = (w_occ < 3'd2);

  assign req_ready  = (r_state == ST_IDLE) && w_credit && !reset;
  assign w_accept   = req_valid && req_ready;
  assign w_is_write = |req_wen;

  // Next-state and issue decode; writes complete in the acceptance cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr         = 1'b0;
    w_rd_issue   = 1'b0;
    w_issue_last = 1'b0;
    w_issue_addr = req_addr;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_write) begin
            w_wr = 1'b1;
          end else begin
            w_rd_issue   = 1'b1;
            w_issue_last = (req_len == '0);
            if (req_len != '0) w_state_nxt = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        w_issue_addr = r_addr;
        if (w_credit) begin
          w_rd_issue   = 1'b1;
          w_issue_last = (r_idx == r_len);
          if (r_idx == r_len) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Burst address and beat counter; beat 0 is issued from IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_idx  <= '0;
      r_len  <= '0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_BURST) begin
      r_addr <= req_addr + ADDR_W'(NBANKS);
      r_idx  <= LEN_W'(1);
      r_len  <= req_len;
    end else if (r_state == ST_BURST && w_rd_issue) begin
      r_addr <= r_addr + ADDR_W'(NBANKS);
      r_idx  <= r_idx + LEN_W'(1);
    end
  end

  // Banks below the rotation point hold words from the next row; the row
  // increment wraps naturally so accesses past the top fold back to word 0.
  assign w_base_row = w_issue_addr[ADDR_W-1:SHIFT_W];
  assign w_shift    = w_issue_addr[SHIFT_W-1:0];
  assign w_row_next = w_base_row + ROW_W'(1);

  // Rotate write lanes and byte enables left by the word offset.
  always_comb begin
    logic [SHIFT_W-1:0] lane;
    lane         = '0;
    w_bank_wdata = '0;
    w_bank_wen   = '0;
    for (int b = 0; b < NBANKS; b++) begin
      lane = SHIFT_W'(b) - w_shift;
      w_bank_wdata[b*LANE_W +: LANE_W] = req_wdata[int'(lane)*LANE_W +: LANE_W];
      if (w_wr)
        w_bank_wen[b*BYTES_PER_LANE +: BYTES_PER_LANE] =
          req_wen[int'(lane)*BYTES_PER_LANE +: BYTES_PER_LANE];
    end
  end

  generate
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic [ROW_W-1:0] w_row;
      assign w_row = (SHIFT_W'(b) < w_shift) ? w_row_next : w_base_row;

      mlaccel_bankmem_ram #(
        .DEPTH (BANK_DEPTH)
      ) u_ram (
        .clock (clock),
        .addr  (w_row),
        .wen   (w_bank_wen[b*BYTES_PER_LANE +: BYTES_PER_LANE]),
        .wdata (w_bank_wdata[b*LANE_W +: LANE_W]),
        .rdata (w_bank_rdata[b*LANE_W +: LANE_W])
      );
    end
  endgenerate

  // Rotate bank outputs right by the offset captured with the request.
  always_comb begin
    logic [SHIFT_W-1:0] bank;
    bank        = '0;
    w_rot_rdata = '0;
    for (int i = 0; i < NBANKS; i++) begin
      bank = SHIFT_W'(i) + r_rd_shift;
      w_rot_rdata[i*LANE_W +: LANE_W] = w_bank_rdata[int'(bank)*LANE_W +: LANE_W];
    end
  end

  // Read stage: tracks the beat currently being read out of the banks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_shift <= '0;
    end else begin
      r_rd_valid <= w_rd_issue;
      r_rd_last  <= w_issue_last;
      r_rd_shift <= w_shift;
    end
  end

  // Two-entry response FIFO; its entries double as the rotate register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
      r_fifo_last <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= '0;
    end else begin
      if (r_rd_valid) begin
        r_fifo_data[r_wptr] <= w_rot_rdata;
        r_fifo_last[r_wptr] <= r_rd_last;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(r_rd_valid) - 2'(w_pop);
    end
  end

  assign rsp_valid = (r_count != 2'd0);
  assign rsp_data  = r_fifo_data[r_rptr];
  assign rsp_last  = r_fifo_last[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_mlaccel_bankmem.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlaccel_bankmem
// Description : Directed self-checking bench for mlaccel_bankmem (NBANKS=4):
//               aligned/unaligned access, byte enables, bursts, backpressure,
//               address wrap and reset during a burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlaccel_bankmem;

  localparam int NB = 4;
  localparam int DEPTH = 16384;
  localparam int AW = 16;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wen;
  logic [63:0]   req_wdata;
  logic [LW-1:0] req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [63:0]   rsp_data;
  logic          rsp_last;

  int checks = 0;
  int errors = 0;

  // Word-level shadow of everything the bench has written.
  logic [15:0] mdl [0:65535];

  mlaccel_bankmem #(
    .NBANKS(NB), .BANK_DEPTH(DEPTH), .ADDR_W(AW), .LEN_W(LW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mbeat(input logic [15:0] a);
    logic [63:0] r;
    logic [15:0] w;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      w = a + 16'(i);
      r[16*i +: 16] = mdl[w];
    end
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk(tag, req_ready, 1'b1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] be, input logic [63:0] d);
    logic [15:0] w;
    @(negedge clock);
    req_valid = 1'b1; req_addr = a; req_wen = be; req_wdata = d; req_len = '0;
    wait_ready("wr_ready");
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_wen = '0;
    for (int i = 0; i < NB; i++) begin
      w = a + 16'(i);
      if (be[2*i])   mdl[w][7:0]  = d[16*i +: 8];
      if (be[2*i+1]) mdl[w][15:8] = d[16*i+8 +: 8];
    end
  endtask

  // Returns one time unit after the acceptance edge.
  task automatic rd_issue(input logic [15:0] a, input logic [LW-1:0] len);
    @(negedge clock);
    req_valid = 1'b1; req_addr = a; req_wen = '0; req_wdata = '0; req_len = len;
    wait_ready("rd_ready");
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_len = '0;
  endtask

  task automatic rd1(input string tag, input logic [15:0] a, input logic [63:0] exp);
    rd_issue(a, '0);
    @(negedge clock);
    chk({tag, "_valid_t1"}, rsp_valid, 1'b0);
    @(negedge clock);
    chk({tag, "_valid_t2"}, rsp_valid, 1'b1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_last"}, rsp_last, 1'b1);
  endtask

  initial begin
    logic [63:0] b4 [4];
    logic [63:0] d;
    logic [15:0] a;
    int beats;

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = '0;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data",  rsp_data,  64'h0);
    chk("rst_rsp_last",  rsp_last,  1'b0);
    reset = 1'b0;
    #1;
    chk("rel_req_ready", req_ready, 1'b1);

    // Aligned write then read, two-cycle latency
    wr(16'h0010, 8'hFF, 64'h4444_3333_2222_1111);
    rd1("t1_aligned", 16'h0010, 64'h4444_3333_2222_1111);

    // Unaligned read across a row boundary
    wr(16'h0014, 8'hFF, 64'h8888_7777_6666_5555);
    rd1("t2_unaligned", 16'h0011, 64'h5555_4444_3333_2222);

    // Byte enable: high byte of word 0x12 only
    wr(16'h0012, 8'h02, 64'h0000_0000_0000_AB00);
    rd1("t3_byte_en", 16'h0012, 64'h6666_5555_4444_AB33);

    // Unaligned write overlapping two rows
    wr(16'h0018, 8'hFF, 64'h0303_0202_0101_9999);
    wr(16'h001C, 8'hFF, 64'h0707_0606_0505_0404);
    wr(16'h0019, 8'hFF, 64'hDDDD_CCCC_BBBB_AAAA);
    rd1("t3_unaligned_wr", 16'h0018, 64'hCCCC_BBBB_AAAA_9999);

    // Burst of four with rsp_ready high
    b4[0] = 64'h4444_AB33_2222_1111;
    b4[1] = 64'h8888_7777_6666_5555;
    b4[2] = 64'hCCCC_BBBB_AAAA_9999;
    b4[3] = 64'h0707_0606_0505_DDDD;
    rd_issue(16'h0010, 4'd3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      chk($sformatf("t4_req_ready_c%0d", c), req_ready, (c >= 4));
      chk($sformatf("t4_rsp_valid_c%0d", c), rsp_valid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        chk($sformatf("t4_data_b%0d", c - 2), rsp_data, b4[c-2]);
        chk($sformatf("t4_last_b%0d", c - 2), rsp_last, (c == 5));
      end
    end

    // Backpressure: eight beats with rsp_ready toggling
    for (int k = 0; k < 4; k++) begin
      a = 16'h0020 + 16'(4 * k);
      for (int i = 0; i < NB; i++) d[16*i +: 16] = 16'h5A00 + a + 16'(i);
      wr(a, 8'hFF, d);
    end
    rd_issue(16'h0010, 4'd7);
    beats = 0;
    for (int c = 0; c < 60 && beats < 8; c++) begin
      @(negedge clock);
      rsp_ready = (c % 2 == 0);
      #1;
      if (rsp_valid) begin
        chk($sformatf("t5_data_b%0d", beats), rsp_data, mbeat(16'h0010 + 16'(4 * beats)));
        chk($sformatf("t5_last_b%0d", beats), rsp_last, (beats == 7));
        if (rsp_ready) beats++;
      end
    end
    chk("t5_beat_count", beats, 8);
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("t5_no_extra_%0d", c), rsp_valid, 1'b0);
    end

    // Address wrap past the top of memory
    wr(16'hFFFC, 8'hFF, 64'hF3F3_F2F2_F1F1_F0F0);
    wr(16'h0000, 8'hFF, 64'h0C03_0C02_0C01_0C00);
    rd1("t6_wrap", 16'hFFFE, 64'h0C01_0C00_F3F3_F2F2);

    // Reset in the middle of a long burst
    rd_issue(16'h0010, 4'd7);
    repeat (3) @(negedge clock);
    chk("t6_burst_active", rsp_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_rst_rsp_valid", rsp_valid, 1'b0);
    chk("t6_rst_req_ready", req_ready, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t6_rel_req_ready", req_ready, 1'b1);
    chk("t6_rel_rsp_valid", rsp_valid, 1'b0);
    chk("t6_rel_rsp_data",  rsp_data,  64'h0);
    chk("t6_rel_rsp_last",  rsp_last,  1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("t6_quiet_%0d", c), rsp_valid, 1'b0);
    end
    rd1("t6_post_reset", 16'h0010, 64'h4444_AB33_2222_1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mlaccel_bankmem.md
# mlaccel_bankmem

Parametrised, banked, word-addressed accelerator memory with unaligned multi-word access, valid/ready request and response channels, and multi-beat read bursts. It generalises the fixed four-bank unaligned scratchpad to NBANKS banks of configurable depth. It adds a pipelined response path with backpressure and an auto-incrementing burst engine. It sits between the sequencer/DMA and the per-bank single-port RAMs (SPRAM on iCE40).

## Interface
- NBANKS, 4, number of 16-bit banks; power of two, ≥2; one access spans NBANKS consecutive words
- BANK_DEPTH, 16384, words per bank; power of two
- ADDR_W, 16, word-address width; must equal log2(NBANKS*BANK_DEPTH)
- LEN_W, 4, burst length field width
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_W  first word address, any alignment
- req_wen  in  2*NBANKS  byte enables, bit 2i = lane i low byte; any bit set = write, all zero = read
- req_wdata  in  16*NBANKS  lane i (bits 16i+15:16i) goes to word req_addr+i
- req_len  in  LEN_W  read burst beats minus one; ignored for writes
- rsp_valid  out  1  read beat valid
- rsp_ready  in  1  read beat consumed when rsp_valid && rsp_ready
- rsp_data  out  16*NBANKS  lane i = word (beat_addr+i)
- rsp_last  out  1  final beat of a burst

## Operation
- Word w lives in bank w mod NBANKS, row w / NBANKS. Access at addr uses base row r = addr/NBANKS, rotation s = addr mod NBANKS. Bank b uses row r+1 if b < s, else row r. Row r+1 wraps modulo BANK_DEPTH, so words past the top wrap to 0.
- Write lanes are rotated left by s onto banks, with byte enables rotated identically. Read bank outputs are rotated right by s, using s registered alongside the request.
- FSM: IDLE, BURST.
  - IDLE: a write is accepted and performed in one cycle. It produces no response.
  - A read is accepted and issues beat 0. If req_len=0, the state stays IDLE. Otherwise it latches addr+NBANKS, the remaining count req_len, and the total length, then goes to BURST.
  - BURST: one beat is issued per cycle while credit is available. Address advances by NBANKS per beat, mod 2^ADDR_W. Return to IDLE after the beat with remaining count 0 is issued.
- Response path: one read stage (bank output), then a rotate register feeding a 2-entry FIFO. inflight ∈{0,1} counts beats in the read stage.
- Issue credit: inflight + fifo_count − (rsp_valid && rsp_ready) < 2. This gives full throughput with rsp_ready high and never overflows the FIFO.
- req_ready = (state==IDLE) && credit. It is low for the whole of a burst.
- rsp_last is carried per beat; it is set on the final beat (beat index == len), including len=0.
- Accesses complete in acceptance order. A write accepted after a read never affects that read's data.

## Timing
- Reset values:
  - req_ready 0 while reset is asserted; 1 in the first cycle after release.
  - rsp_valid 0, rsp_data 0, rsp_last 0.
  - FSM IDLE, FIFO empty, inflight 0.
  - RAM contents are not cleared.
- Read latency: a read accepted or issued in cycle t gives rsp_valid in cycle t+2 if the FIFO is empty and no older beats are pending.
- Burst with rsp_ready high: beats in consecutive cycles t+2 … t+2+len. req_ready returns high in cycle t+len+1.
- Stall: rsp_valid && !rsp_ready holds rsp_data and rsp_last stable until the beat is consumed.
- Write: the RAM is updated at the acceptance edge. A read accepted the next cycle sees the new data.
- Reset mid-burst: the burst is aborted, the FIFO and inflight beat are discarded, and rsp_valid drops immediately (async). No partial write is guaranteed for a write accepted in the reset cycle.

## Structure
- Shared package mlaccel_pkg holds:
  - FSM state encoding (ST_IDLE, ST_BURST)
  - a clog2 helper
  - localparams LANE_W=16 and BYTES_PER_LANE=2
- Sub-module mlaccel_bankmem_ram: one bank, BANK_DEPTH×16, synchronous read, 2-bit byte write enable. It is instantiated NBANKS times and maps to SB_SPRAM256KA when BANK_DEPTH=16384.
- The rotate logic, FSM, credit counter and FIFO live in the top module.

## Test plan
1. Aligned write, then read (NBANKS=4):
   - Write 0x0010, wen 0xFF, data {0x4444,0x3333,0x2222,0x1111}.
   - Read 0x0010, len 0 → rsp_data {0x4444,0x3333,0x2222,0x1111}, rsp_last=1, 2 cycles after acceptance.
2. Unaligned read:
   - Additionally write 0x0014 with {0x8888,0x7777,0x6666,0x5555}.
   - Read 0x0011 → {0x5555,0x4444,0x3333,0x2222}.
3. Byte enables: write 0x0012, wen 0x02, lane0 0xAB00. Read 0x0012 → lane0 = 0xAB33; other words unchanged.
4. Burst, rsp_ready high: read 0x0010, len 3.
   - Four beats in consecutive cycles from words 0x10, 0x14, 0x18, 0x1C.
   - rsp_last only on beat 3.
   - req_ready low until the last issue.
5. Backpressure: burst len 7 with rsp_ready toggling 1,0,1,0 → exactly 8 beats, in order, no duplicates; data held stable while stalled; FIFO never exceeds 2.
6. Wrap and reset:
   - Read 0xFFFE → lanes are words 0xFFFE, 0xFFFF, 0x0000, 0x0001.
   - Assert reset during a len-7 burst → rsp_valid 0 at once; req_ready 1 in the first cycle after release.
